uart_frame_parser: RTL and testbench



---
 rtl/uart_frame_pkg.sv | 25 ++
 rtl/uart_frame_parser_sat_counter.sv | 28 ++
 rtl/uart_frame_parser.sv | 258 +++++++++++++++++++++++++
 tb/tb_uart_frame_parser.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: shared types and defaults for the UART frame parser.
//   state_t          parser state encoding
//   CNT_W            width of the saturating error/drop/timeout counters
//   DEF_*            default parameter values for uart_frame_parser
// Optional feature macro: UART_FRAME_TIMEOUT_EN (adds DEF_TIMEOUT_CLKS).
package uart_frame_pkg;

  localparam int unsigned CNT_W           = 8;
  localparam int unsigned DEF_MAX_PAYLOAD = 16;
  localparam logic [7:0]  DEF_SOF_BYTE    = 8'hA5;
  localparam int unsigned DEF_LEN_W       = 5;
`ifdef UART_FRAME_TIMEOUT_EN
  // Three byte times at 200 MHz / 115200 baud.
  localparam int unsigned DEF_TIMEOUT_CLKS = 52080;
`endif

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN     = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_CHK     = 3'd3,
    ST_EMIT    = 3'd4
  } state_t;

endpackage

// File: rtl/uart_frame_parser_sat_counter.sv
// sat_counter: CNT_W-bit event counter that sticks at all-ones.
//   i_Clock  clock (rising edge)
//   i_Reset  synchronous active-high reset, clears the count
//   i_Inc    count one event this cycle
//   o_Count  registered count
module sat_counter
  import uart_frame_pkg::*;
(
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Inc,
  output logic [CNT_W-1:0] o_Count
);

  logic [CNT_W-1:0] r_count;

  // Increment unless already saturated.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_count <= '0;
    end else if (i_Inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_Count = r_count;

endmodule

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: assembles SOF/LEN/payload/XOR-checksum frames from a
// UART byte stream and replays good payloads as a valid/ready byte stream.
//   i_Clock, i_Reset        clock, synchronous active-high reset
//   i_Rx_DV, i_Rx_Byte      one-cycle received-byte strobe and byte
//   o_Data_Valid/o_Data     payload beat, o_Data_Last on the final beat
//   i_Data_Ready            downstream accepts the current beat
//   o_Frame_Len             LEN of the frame being emitted
//   o_Err_Checksum_Count    saturating checksum-failure count
//   o_Err_Length_Count      saturating illegal-LEN count
//   o_Drop_Count            saturating count of bytes received while emitting
//   o_Timeout_Count         saturating inter-byte timeout count
// Optional feature macro: UART_FRAME_TIMEOUT_EN enables the inter-byte
// timeout (parameter TIMEOUT_CLKS); without it o_Timeout_Count is 0.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter int unsigned MAX_PAYLOAD = DEF_MAX_PAYLOAD,
  parameter logic [7:0]  SOF_BYTE    = DEF_SOF_BYTE,
  parameter int unsigned LEN_W       = DEF_LEN_W
`ifdef UART_FRAME_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CLKS = DEF_TIMEOUT_CLKS
`endif
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Rx_DV,
  input  logic [7:0]       i_Rx_Byte,
  output logic             o_Data_Valid,
  output logic [7:0]       o_Data,
  output logic             o_Data_Last,
  input  logic             i_Data_Ready,
  output logic [LEN_W-1:0] o_Frame_Len,
  output logic [CNT_W-1:0] o_Err_Checksum_Count,
  output logic [CNT_W-1:0] o_Err_Length_Count,
  output logic [CNT_W-1:0] o_Drop_Count,
  output logic [CNT_W-1:0] o_Timeout_Count
);

  localparam int unsigned IDX_W = $clog2(MAX_PAYLOAD);

  state_t           r_state;
  state_t           w_next_state;

  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_wr_idx;
  logic [LEN_W-1:0] r_rd_idx;
  logic [LEN_W-1:0] r_frame_len;
  logic [7:0]       r_chk;
  logic [7:0]       r_data;
  logic             r_data_valid;
  logic             r_data_last;
  logic [7:0]       r_buf [MAX_PAYLOAD];

  logic             w_len_bad;
  logic             w_len_load;
  logic             w_len_err;
  logic             w_pay_wr;
  logic             w_pay_last;
  logic             w_emit_start;
  logic             w_chk_err;
  logic             w_xfer;
  logic             w_drop;
  logic [LEN_W-1:0] w_len_m1;
  logic [LEN_W-1:0] w_rd_next;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CLKS);

  logic [TMR_W-1:0] r_timer;
  logic             w_timer_active;
  logic             w_timeout;
`endif

  assign w_len_bad = (i_Rx_Byte == 8'd0) || (i_Rx_Byte > 8'(MAX_PAYLOAD));
  assign w_len_m1  = r_len - LEN_W'(1);
  assign w_rd_next = r_rd_idx + LEN_W'(1);
  assign w_xfer    = r_data_valid && i_Data_Ready;

  // State register.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode and datapath strobes.
  always_comb begin
    w_next_state = r_state;
    w_len_load   = 1'b0;
    w_len_err    = 1'b0;
    w_pay_wr     = 1'b0;
    w_pay_last   = 1'b0;
    w_emit_start = 1'b0;
    w_chk_err    = 1'b0;
    w_drop       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
          w_next_state = ST_LEN;
        end
      end
      ST_LEN: begin
        // A rejected LEN byte is consumed, never re-examined as SOF.
        if (i_Rx_DV) begin
          if (w_len_bad) begin
            w_len_err    = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_len_load   = 1'b1;
            w_next_state = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_Rx_DV) begin
          w_pay_wr = 1'b1;
          if (r_wr_idx == w_len_m1) begin
            w_pay_last   = 1'b1;
            w_next_state = ST_CHK;
          end
        end
      end
      ST_CHK: begin
        if (i_Rx_DV) begin
          if (i_Rx_Byte == r_chk) begin
            w_emit_start = 1'b1;
            w_next_state = ST_EMIT;
          end else begin
            w_chk_err    = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        // No buffering behind the emitting frame: every arrival is dropped.
        w_drop = i_Rx_DV;
        if (w_xfer && r_data_last) begin
          w_next_state = ST_IDLE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase

`ifdef UART_FRAME_TIMEOUT_EN
    // Expiry only fires on a byteless cycle, so no strobe above is active.
    if (w_timeout) begin
      w_next_state = ST_IDLE;
    end
`endif
  end

  // Length/checksum capture and registered output beat.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_len        <= '0;
      r_wr_idx     <= '0;
      r_rd_idx     <= '0;
      r_frame_len  <= '0;
      r_chk        <= '0;
      r_data       <= '0;
      r_data_valid <= 1'b0;
      r_data_last  <= 1'b0;
    end else begin
      if (w_len_load) begin
        r_len    <= LEN_W'(i_Rx_Byte);
        r_chk    <= i_Rx_Byte;
        r_wr_idx <= '0;
      end
      if (w_pay_wr) begin
        r_chk    <= r_chk ^ i_Rx_Byte;
        r_wr_idx <= w_pay_last ? '0 : (r_wr_idx + LEN_W'(1));
      end
      if (w_emit_start) begin
        r_data_valid <= 1'b1;
        r_data       <= r_buf[0];
        r_data_last  <= (r_len == LEN_W'(1));
        r_frame_len  <= r_len;
        r_rd_idx     <= '0;
      end else if (w_xfer) begin
        if (r_data_last) begin
          r_data_valid <= 1'b0;
        end else begin
          // Prefetch the next beat so outputs stay registered.
          r_rd_idx    <= w_rd_next;
          r_data      <= r_buf[IDX_W'(w_rd_next)];
          r_data_last <= (w_rd_next == w_len_m1);
        end
      end
    end
  end

  // Payload buffer; contents are don't-care across reset.
  always_ff @(posedge i_Clock) begin
    if (w_pay_wr) begin
      r_buf[IDX_W'(r_wr_idx)] <= i_Rx_Byte;
    end
  end

  assign o_Data_Valid = r_data_valid;
  assign o_Data       = r_data;
  assign o_Data_Last  = r_data_last;
  assign o_Frame_Len  = r_frame_len;

  sat_counter u_chk_cnt (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Inc   (w_chk_err),
    .o_Count (o_Err_Checksum_Count)
  );

  sat_counter u_len_cnt (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Inc   (w_len_err),
    .o_Count (o_Err_Length_Count)
  );

  sat_counter u_drop_cnt (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Inc   (w_drop),
    .o_Count (o_Drop_Count)
  );

`ifdef UART_FRAME_TIMEOUT_EN
  assign w_timer_active = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) ||
                          (r_state == ST_CHK);
  assign w_timeout      = w_timer_active && !i_Rx_DV &&
                          (r_timer == TMR_W'(TIMEOUT_CLKS - 1));

  // Inter-byte timer: cleared by every byte, held at zero outside the frame.
  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      r_timer <= '0;
    end else if (i_Rx_DV || !w_timer_active || w_timeout) begin
      r_timer <= '0;
    end else begin
      r_timer <= r_timer + TMR_W'(1);
    end
  end

  sat_counter u_to_cnt (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Inc   (w_timeout),
    .o_Count (o_Timeout_Count)
  );
`else
  assign o_Timeout_Count = '0;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb_uart_frame_parser: randomized scoreboard bench for uart_frame_parser.
// Frames are generated at the frame level; good frames push their expected
// beats, bad frames bump expected error counts. A monitor pops beats as they
// are handshaken and checks stability under backpressure.
module tb_uart_frame_parser;

  localparam int unsigned LEN_W = 5;
  localparam int unsigned MAXP  = 16;
  localparam int unsigned TMO   = 100;
  localparam logic [7:0]  SOF   = 8'hA5;

  logic             clk = 1'b0;
  logic             rst;
  logic             dv;
  logic [7:0]       rx_byte;
  logic             ready;
  logic             o_valid;
  logic [7:0]       o_data;
  logic             o_last;
  logic [LEN_W-1:0] o_len;
  logic [7:0]       c_chk, c_len, c_drop, c_to;

  typedef struct {
    logic [7:0]       data;
    logic             last;
    logic [LEN_W-1:0] len;
  } beat_t;

  beat_t      exp_q[$];
  logic [7:0] pl[$];
  int         vectors    = 0;
  int         miscompares = 0;
  int         e_chk, e_len, e_drop, e_to;
  int         rmode = 0;

`ifdef UART_FRAME_TIMEOUT_EN
  uart_frame_parser #(.MAX_PAYLOAD(MAXP), .SOF_BYTE(SOF), .LEN_W(LEN_W), .TIMEOUT_CLKS(TMO)) dut (
`else
  uart_frame_parser #(.MAX_PAYLOAD(MAXP), .SOF_BYTE(SOF), .LEN_W(LEN_W)) dut (
`endif
    .i_Clock              (clk),
    .i_Reset              (rst),
    .i_Rx_DV              (dv),
    .i_Rx_Byte            (rx_byte),
    .o_Data_Valid         (o_valid),
    .o_Data               (o_data),
    .o_Data_Last          (o_last),
    .i_Data_Ready         (ready),
    .o_Frame_Len          (o_len),
    .o_Err_Checksum_Count (c_chk),
    .o_Err_Length_Count   (c_len),
    .o_Drop_Count         (c_drop),
    .o_Timeout_Count      (c_to)
  );

  always #5 clk = ~clk;

  function automatic int sat(input int v);
    return (v > 255) ? 255 : v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    dv      = 1'b1;
    rx_byte = b;
    @(posedge clk);
    #1;
    dv      = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic make_payload(input int n);
    pl.delete();
    repeat (n) pl.push_back(8'($urandom));
  endtask

  function automatic logic [7:0] frame_xor();
    logic [7:0] x;
    x = 8'(pl.size());
    foreach (pl[i]) x ^= pl[i];
    return x;
  endfunction

  task automatic push_exp();
    int n;
    n = pl.size();
    foreach (pl[i]) exp_q.push_back('{pl[i], (i == n - 1), LEN_W'(n)});
  endtask

  task automatic send_frame(input bit corrupt, input int gap_max, input bit lat_chk);
    logic [7:0] x;
    x = frame_xor();
    if (corrupt) e_chk = sat(e_chk + 1);
    else         push_exp();
    send_byte(SOF);
    idle($urandom_range(0, gap_max));
    send_byte(8'(pl.size()));
    foreach (pl[i]) begin
      idle($urandom_range(0, gap_max));
      send_byte(pl[i]);
    end
    idle($urandom_range(0, gap_max));
    if (lat_chk) check("valid_before_chk", {31'd0, o_valid}, 32'd0);
    send_byte(corrupt ? (x ^ 8'($urandom_range(1, 255))) : x);
    if (lat_chk) check("latency_1cyc", {31'd0, o_valid}, 32'd1);
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d beats outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
    idle(2);
  endtask

  task automatic check_counters(input string name);
    check({name, "_err_chk"}, {24'd0, c_chk},  32'(e_chk));
    check({name, "_err_len"}, {24'd0, c_len},  32'(e_len));
    check({name, "_drop"},    {24'd0, c_drop}, 32'(e_drop));
    check({name, "_timeout"}, {24'd0, c_to},   32'(e_to));
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_valid"}, {31'd0, o_valid}, 32'd0);
    check({name, "_data"},  {24'd0, o_data},  32'd0);
    check({name, "_last"},  {31'd0, o_last},  32'd0);
    check({name, "_len"},   32'(o_len),       32'd0);
  endtask

  // Ready driver: 0 = always ready, 1 = random, 2 = stalled.
  initial begin
    ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(0, 3) != 0);
        default: ready = 1'b0;
      endcase
    end
  end

  // Monitor: pop on handshake, check hold while stalled.
  initial begin
    logic             hold_p;
    logic [7:0]       hd;
    logic             hl;
    logic [LEN_W-1:0] hn;
    beat_t            b;
    hold_p = 1'b0;
    hd = '0; hl = 1'b0; hn = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_p = 1'b0;
      end else begin
        if (hold_p) begin
          vectors++;
          if (!o_valid || o_data !== hd || o_last !== hl || o_len !== hn) begin
            miscompares++;
            $display("FAIL hold: got v=%0b d=%0h l=%0b n=%0d expected v=1 d=%0h l=%0b n=%0d",
                     o_valid, o_data, o_last, o_len, hd, hl, hn);
          end
        end
        hold_p = 1'b0;
        if (o_valid) begin
          if (ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_beat: got d=%0h l=%0b expected no beat", o_data, o_last);
            end else begin
              b = exp_q.pop_front();
              if (o_data !== b.data || o_last !== b.last || o_len !== b.len) begin
                miscompares++;
                $display("FAIL beat: got d=%0h l=%0b n=%0d expected d=%0h l=%0b n=%0d",
                         o_data, o_last, o_len, b.data, b.last, b.len);
              end
            end
          end else begin
            hold_p = 1'b1;
            hd = o_data; hl = o_last; hn = o_len;
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] b;
    int         kind;
    rst = 1'b1; dv = 1'b0; rx_byte = '0;
    e_chk = 0; e_len = 0; e_drop = 0; e_to = 0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    check_counters("reset");
    rst = 1'b0;
    idle(2);

    // Directed good frame with single-cycle latency check.
    pl.delete();
    pl.push_back(8'h11); pl.push_back(8'h22); pl.push_back(8'h33);
    send_frame(1'b0, 0, 1'b1);
    wait_drain("good1");
    check_counters("good1");

    // Bad checksum, then LEN 0 and LEN 17.
    send_byte(SOF); send_byte(8'h02); send_byte(8'h01); send_byte(8'h02); send_byte(8'hFF);
    e_chk = sat(e_chk + 1);
    send_byte(SOF); send_byte(8'h00);
    send_byte(SOF); send_byte(8'h11);
    e_len = sat(e_len + 2);
    idle(3);
    check_counters("bad");
    make_payload(5);
    send_frame(1'b0, 1, 1'b0);
    wait_drain("after_bad");

    // Backpressure with a byte dropped during EMIT.
    rmode = 2;
    idle(2);
    make_payload(4);
    send_frame(1'b0, 0, 1'b0);
    idle(3);
    send_byte(8'($urandom));
    e_drop = sat(e_drop + 1);
    idle(6);
    rmode = 0;
    wait_drain("stall");
    check_counters("stall");

    // Noise then boundary lengths 1 and MAXP.
    send_byte(8'h00); send_byte(8'hFF); send_byte(8'h12);
    make_payload(1);
    send_frame(1'b0, 0, 1'b1);
    wait_drain("len1");
    make_payload(MAXP);
    send_frame(1'b0, 2, 1'b0);
    wait_drain("lenmax");
    check_counters("noise");

    // Reset mid-payload.
    send_byte(SOF); send_byte(8'h04); send_byte(8'hAA); send_byte(8'hBB);
    rst = 1'b1;
    @(posedge clk);
    #1;
    e_chk = 0; e_len = 0; e_drop = 0; e_to = 0;
    check_outputs_zero("midreset");
    check_counters("midreset");
    rst = 1'b0;
    idle(1);
    make_payload(3);
    send_frame(1'b0, 0, 1'b0);
    wait_drain("post_reset");

    // Randomized mix with random backpressure.
    rmode = 1;
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 3);
      case (kind)
        0: begin
          make_payload($urandom_range(1, MAXP));
          send_frame(1'b0, 3, 1'b0);
        end
        1: begin
          make_payload($urandom_range(1, MAXP));
          send_frame(1'b1, 3, 1'b0);
        end
        2: begin
          b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAXP + 1, 255));
          send_byte(SOF);
          send_byte(b);
          e_len = sat(e_len + 1);
        end
        default: begin
          repeat ($urandom_range(1, 4)) begin
            b = 8'($urandom);
            if (b == SOF) b = 8'h00;
            send_byte(b);
          end
        end
      endcase
      wait_drain("rand");
    end
    rmode = 0;
    idle(2);
    check_counters("rand");

`ifdef UART_FRAME_TIMEOUT_EN
    // Partial frame abandoned: timeout, then late bytes ignored in IDLE.
    pl.delete(); pl.push_back(8'h01); pl.push_back(8'h02);
    send_byte(SOF); send_byte(8'h02); send_byte(8'h01);
    idle(TMO);
    e_to = sat(e_to + 1);
    send_byte(8'h02); send_byte(frame_xor());
    idle(3);
    check_counters("timeout");
    // Bytes landing exactly on the expiry cycle keep the frame alive.
    push_exp();
    send_byte(SOF); send_byte(8'h02); send_byte(8'h01);
    idle(TMO - 1);
    send_byte(8'h02);
    idle(TMO - 1);
    send_byte(frame_xor());
    wait_drain("at_expiry");
    check_counters("at_expiry");
`else
    // Without the timer a slow frame still completes.
    pl.delete(); pl.push_back(8'h01); pl.push_back(8'h02);
    push_exp();
    send_byte(SOF); send_byte(8'h02); send_byte(8'h01);
    idle(TMO + 50);
    send_byte(8'h02);
    idle(TMO + 50);
    send_byte(frame_xor());
    wait_drain("slow");
    check_counters("slow");
`endif

    // Saturation of the length error counter.
    for (int i = 0; i < 258; i++) begin
      send_byte(SOF);
      send_byte(8'h00);
      e_len = sat(e_len + 1);
    end
    idle(2);
    check_counters("saturate");
    make_payload(2);
    send_frame(1'b0, 0, 1'b0);
    wait_drain("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
